fifo_rr_arbiter: RTL and testbench

//  Shares one valid-ready FIFO write port among NUM_REQ requesters.

---
 rtl/fifo_rr_arbiter_pkg.sv | 23 ++
 rtl/fifo_rr_arbiter_if.sv | 27 ++
 rtl/fifo_rr_arbiter_picker.sv | 26 ++
 rtl/fifo_rr_arbiter.sv | 167 ++++++++++++++++
 tb/tb_fifo_rr_arbiter.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_rr_arbiter_pkg.sv
// Shared types and the round-robin selection rule for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    localparam int RR_MAX_REQ = 32;

    // First set bit of v scanning p+1, p+2, ... mod n; p itself is visited last. -1 if v is empty.
    function automatic int rr_pick(input logic [RR_MAX_REQ-1:0] v, input int n, input int p);
        int idx;
        rr_pick = -1;
        for (int k = RR_MAX_REQ; k >= 1; k--) begin
            if (k <= n) begin
                idx = (p + k) % n;
                if (v[idx[4:0]]) rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/fifo_rr_arbiter_if.sv
// Requester-side and FIFO-side handshake bundle of the round-robin write-port arbiter.
interface fifo_rr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int ID_WIDTH = $clog2(NUM_REQ);

    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [DATA_WIDTH-1:0]         out_data;
    logic [ID_WIDTH-1:0]           out_id;
    logic                          out_valid;
    logic                          out_ready;
    logic [ID_WIDTH-1:0]           grant_id;
    logic                          grant_valid;

    modport master (
        input  req_data, req_valid, out_ready,
        output req_ready, out_data, out_id, out_valid, grant_id, grant_valid
    );

    modport slave (
        output req_data, req_valid, out_ready,
        input  req_ready, out_data, out_id, out_valid, grant_id, grant_valid
    );
endinterface

// File: rtl/fifo_rr_arbiter_picker.sv
// Round-robin priority picker: chooses the next requester after last_id, wrapping modulo NUM_REQ.
module rr_priority_picker
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_id,
    output logic [$clog2(NUM_REQ)-1:0] pick_id,
    output logic                       pick_valid
);
    localparam int ID_WIDTH = $clog2(NUM_REQ);

    logic [RR_MAX_REQ-1:0] req_ext;
    int                    pick;

    always_comb begin
        req_ext                = '0;
        req_ext[NUM_REQ-1:0]   = req;
        pick                   = rr_pick(req_ext, NUM_REQ, int'(last_id));
    end

    assign pick_valid = |req;
    assign pick_id    = ID_WIDTH'(pick);

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin, burst-locking arbiter sharing one valid-ready FIFO write port among NUM_REQ requesters.
// Define FIFO_ARB_OUT_REG_EN to put a 2-entry skid slice on out_data/out_id/out_valid.
module fifo_rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    fifo_rr_arbiter_if.master   bus
);
    localparam int ID_WIDTH  = $clog2(NUM_REQ);
    localparam int CNT_WIDTH = $clog2(MAX_BURST) + 1;

    arb_state_t            state_q, state_d;
    logic [ID_WIDTH-1:0]   grant_id_q, grant_id_d;
    logic [ID_WIDTH-1:0]   last_id_q, last_id_d;
    logic [CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
    logic [ID_WIDTH-1:0]   pick_base, pick_id;
    logic                  pick_valid;
    logic                  granted, g_valid, accept, beat_xfer, last_beat, release_grant;
    logic [DATA_WIDTH-1:0] g_data;
    logic [NUM_REQ-1:0]    req_ready;

    assign granted       = (state_q == ARB_GRANT);
    assign g_valid       = bus.req_valid[grant_id_q];
    assign g_data        = bus.req_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
    assign beat_xfer     = granted & g_valid & accept;
    assign last_beat     = (beat_cnt_q == CNT_WIDTH'(MAX_BURST - 1));
    assign release_grant = granted & ((beat_xfer & last_beat) | ~g_valid);
    // While granted, the owner is the round-robin base so a release regrants with no idle bubble.
    assign pick_base     = granted ? grant_id_q : last_id_q;

    rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req        (bus.req_valid),
        .last_id    (pick_base),
        .pick_id    (pick_id),
        .pick_valid (pick_valid)
    );

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        last_id_d  = last_id_q;
        beat_cnt_d = beat_cnt_q;
        if (clear) begin
            state_d    = ARB_IDLE;
            grant_id_d = '0;
            last_id_d  = ID_WIDTH'(NUM_REQ - 1);
            beat_cnt_d = '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        state_d    = ARB_GRANT;
                        grant_id_d = pick_id;
                        beat_cnt_d = '0;
                    end
                end
                default: begin
                    if (release_grant) begin
                        last_id_d  = grant_id_q;
                        beat_cnt_d = '0;
                        if (pick_valid) grant_id_d = pick_id;
                        else            state_d    = ARB_IDLE;
                    end else if (beat_xfer) begin
                        beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            grant_id_q <= '0;
            last_id_q  <= ID_WIDTH'(NUM_REQ - 1);
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            last_id_q  <= last_id_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        req_ready = '0;
        if (granted) req_ready[grant_id_q] = accept;
    end

    assign bus.req_ready   = req_ready;
    assign bus.grant_id    = grant_id_q;
    assign bus.grant_valid = granted;

`ifdef FIFO_ARB_OUT_REG_EN
    logic [1:0]            slice_cnt_q, slice_cnt_d;
    logic [DATA_WIDTH-1:0] slot0_data_q, slot0_data_d, slot1_data_q, slot1_data_d;
    logic [ID_WIDTH-1:0]   slot0_id_q, slot0_id_d, slot1_id_q, slot1_id_d;
    logic                  slice_pop;

    assign accept    = (slice_cnt_q != 2'd2) & ~clear;
    assign slice_pop = (slice_cnt_q != 2'd0) & bus.out_ready & ~clear;

    // slot0 is always the head, so the outputs come straight from flops.
    always_comb begin
        slice_cnt_d  = slice_cnt_q;
        slot0_data_d = slot0_data_q;
        slot0_id_d   = slot0_id_q;
        slot1_data_d = slot1_data_q;
        slot1_id_d   = slot1_id_q;
        case ({beat_xfer, slice_pop})
            2'b10: begin
                if (slice_cnt_q == 2'd0) begin
                    slot0_data_d = g_data;
                    slot0_id_d   = grant_id_q;
                end else begin
                    slot1_data_d = g_data;
                    slot1_id_d   = grant_id_q;
                end
                slice_cnt_d = slice_cnt_q + 2'd1;
            end
            2'b01: begin
                slot0_data_d = slot1_data_q;
                slot0_id_d   = slot1_id_q;
                slice_cnt_d  = slice_cnt_q - 2'd1;
            end
            2'b11: begin
                slot0_data_d = g_data;
                slot0_id_d   = grant_id_q;
            end
            default: ;
        endcase
        if (clear) slice_cnt_d = 2'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slice_cnt_q  <= 2'd0;
            slot0_data_q <= '0;
            slot0_id_q   <= '0;
            slot1_data_q <= '0;
            slot1_id_q   <= '0;
        end else begin
            slice_cnt_q  <= slice_cnt_d;
            slot0_data_q <= slot0_data_d;
            slot0_id_q   <= slot0_id_d;
            slot1_data_q <= slot1_data_d;
            slot1_id_q   <= slot1_id_d;
        end
    end

    assign bus.out_valid = (slice_cnt_q != 2'd0) & ~clear;
    assign bus.out_data  = slot0_data_q;
    assign bus.out_id    = slot0_id_q;
`else
    assign accept        = bus.out_ready & ~clear;
    assign bus.out_valid = granted & g_valid & ~clear;
    assign bus.out_data  = granted ? g_data : '0;
    assign bus.out_id    = granted ? grant_id_q : '0;
`endif

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Randomised bench for fifo_rr_arbiter with a queue-based behavioural reference model.
module tb_fifo_rr_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst;
    logic clear;
    always #5 clk = ~clk;

    fifo_rr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

    fifo_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .bus   (bus)
    );

    typedef struct {
        int            id;
        logic [DW-1:0] d;
    } beat_t;

    int    n_checks = 0;
    int    n_fail   = 0;
    bit    chk_en   = 1'b0;
    bit    m_busy;
    int    m_owner, m_last, m_beats;
    beat_t m_q[$];
    int    log_id[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pick_m(input logic [N-1:0] v, input int p);
        for (int k = 1; k <= N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [DW-1:0] data_of(input int i);
        return bus.req_data[i*DW +: DW];
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_last  = N - 1;
        m_beats = 0;
        m_q.delete();
    endtask

    // Outputs are compared at the negedge, then the model advances to the following posedge.
    always @(negedge clk) begin : model_chk
        logic [N-1:0]  v, exp_rdy;
        logic          exp_ov, acc, xfer;
        logic [DW-1:0] exp_od;
        int            exp_oid, g;
        if (chk_en) begin
            v = bus.req_valid;
            if (rst) begin
                chk("rst_req_ready", 32'(bus.req_ready), 0);
                chk("rst_out_valid", 32'(bus.out_valid), 0);
                chk("rst_grant_valid", 32'(bus.grant_valid), 0);
                model_reset();
            end else begin
                g = m_owner;
`ifdef FIFO_ARB_OUT_REG_EN
                acc     = (m_q.size() < 2) && !clear;
                exp_ov  = (m_q.size() > 0) && !clear;
                exp_od  = exp_ov ? m_q[0].d : '0;
                exp_oid = exp_ov ? m_q[0].id : 0;
`else
                acc     = bus.out_ready && !clear;
                exp_ov  = m_busy && v[g] && !clear;
                exp_od  = data_of(g);
                exp_oid = g;
`endif
                exp_rdy = '0;
                if (m_busy) exp_rdy[g] = acc;
                chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
                chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
                chk("grant_valid", 32'(bus.grant_valid), 32'(m_busy));
                chk("grant_id", 32'(bus.grant_id), 32'(m_owner));
                if (exp_ov) begin
                    chk("out_data", 32'(bus.out_data), 32'(exp_od));
                    chk("out_id", 32'(bus.out_id), 32'(exp_oid));
                end
                if (bus.out_valid && bus.out_ready) log_id.push_back(int'(bus.out_id));
                if (clear) begin
                    model_reset();
                end else begin
                    xfer = m_busy && v[g] && acc;
`ifdef FIFO_ARB_OUT_REG_EN
                    if (m_q.size() > 0 && bus.out_ready) void'(m_q.pop_front());
                    if (xfer) m_q.push_back('{id: g, d: data_of(g)});
`endif
                    if (!m_busy) begin
                        if (v != '0) begin
                            m_owner = pick_m(v, m_last);
                            m_busy  = 1'b1;
                            m_beats = 0;
                        end
                    end else if ((xfer && m_beats == MB - 1) || !v[g]) begin
                        m_last  = g;
                        m_beats = 0;
                        if (v != '0) m_owner = pick_m(v, g);
                        else         m_busy  = 1'b0;
                    end else if (xfer) begin
                        m_beats++;
                    end
                end
            end
        end
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            bus.req_data = $urandom;
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        clear         = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.out_ready = 1'b1;
        model_reset();
        chk_en = 1'b1;
        step(2);
        rst = 1'b0;
        chk("reset_grant_valid", 32'(bus.grant_valid), 0);
        chk("reset_grant_id", 32'(bus.grant_id), 0);
        chk("reset_out_valid", 32'(bus.out_valid), 0);
        chk("reset_out_id", 32'(bus.out_id), 0);
        chk("reset_out_data", 32'(bus.out_data), 0);
        chk("reset_req_ready", 32'(bus.req_ready), 0);
        step();

        // Lone requester 0: one idle cycle, then one beat per cycle with regrants at burst edges.
        log_id.delete();
        bus.req_valid = 4'b0001;
        step(9);
`ifdef FIFO_ARB_OUT_REG_EN
        chk("t1_beats", 32'(log_id.size()), 7);
`else
        chk("t1_beats", 32'(log_id.size()), 8);
`endif
        foreach (log_id[i]) chk("t1_id", 32'(log_id[i]), 0);
        bus.req_valid = '0;
        step(3);

        // All requesters valid: 4-beat bursts in 0,1,2,3 order.
        pulse_clear();
        log_id.delete();
        bus.req_valid = 4'b1111;
        step(20);
        chk("t2_count_ge16", 32'(log_id.size() >= 16), 1);
        if (log_id.size() >= 16)
            for (int i = 0; i < 16; i++) chk("t2_seq", 32'(log_id[i]), 32'((i / 4) % 4));
        bus.req_valid = '0;
        step(3);

        // Backpressure mid-burst freezes the grant.
        pulse_clear();
        log_id.delete();
        bus.req_valid = 4'b0110;
        step(3);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_hold_grant", 32'(bus.grant_id), 1);
            chk("t3_hold_valid", 32'(bus.grant_valid), 1);
        end
        bus.out_ready = 1'b1;
        step(10);
        chk("t3_count_ge8", 32'(log_id.size() >= 8), 1);
        if (log_id.size() >= 8)
            for (int i = 0; i < 8; i++) chk("t3_seq", 32'(log_id[i]), (i < 4) ? 1 : 2);
        bus.req_valid = '0;
        step(3);

        // Owner drops valid early: next edge hands over to requester 3.
        pulse_clear();
        bus.req_valid = 4'b0100;
        step(3);
        chk("t4_grant2", 32'(bus.grant_id), 2);
        bus.req_valid = 4'b1000;
        step();
        chk("t4_grant3", 32'(bus.grant_id), 3);
        bus.req_valid = '0;
        step(3);
        chk("t4_idle_grant_valid", 32'(bus.grant_valid), 0);
        chk("t4_idle_out_valid", 32'(bus.out_valid), 0);

        // Asynchronous reset mid-burst, then clear mid-burst.
        bus.req_valid = 4'b1111;
        step(3);
        #2 rst = 1'b1;
        #1;
        chk("t5_async_req_ready", 32'(bus.req_ready), 0);
        chk("t5_async_out_valid", 32'(bus.out_valid), 0);
        chk("t5_async_grant_valid", 32'(bus.grant_valid), 0);
        step(2);
        rst = 1'b0;
        step();
        chk("t5_first_grant", 32'(bus.grant_id), 0);
        chk("t5_first_valid", 32'(bus.grant_valid), 1);
        step(2);
        pulse_clear();
        chk("t5_clear_grant_valid", 32'(bus.grant_valid), 0);
        step();
        chk("t5_clear_regrant", 32'(bus.grant_id), 0);

        // All valid with random backpressure, then fully random traffic.
        for (int i = 0; i < 200; i++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        for (int i = 0; i < 400; i++) begin
            bus.req_valid = 4'($urandom_range(0, 15));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        bus.req_valid = '0;
        bus.out_ready = 1'b1;
        step(5);
        chk("final_idle", 32'(bus.out_valid), 0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
